// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: data-port slave behind the MEM stage. Decodes each request
// to data RAM or an MMIO window (machine timer and a byte TX FIFO). Load data
// is returned combinationally. Stores, timer updates and FIFO moves happen on
// the rising clock edge.
module data_bus_ctrl #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_sel,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_err,
  output logic        o_timer_irq,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready
);

  localparam int AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW  = $clog2(TX_DEPTH);
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

  // Extend an extracted byte lane to 32 bits, signed or unsigned.
  function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic sgn);
    logic signed [7:0]  sv;
    logic signed [31:0] sx;
    sv = v;
    sx = sv;
    return sgn ? sx : {24'd0, v};
  endfunction

  // Extend an extracted half-word lane to 32 bits, signed or unsigned.
  function automatic logic [31:0] ext_half(input logic [15:0] v, input logic sgn);
    logic signed [15:0] sv;
    logic signed [31:0] sx;
    sv = v;
    sx = sv;
    return sgn ? sx : {16'd0, v};
  endfunction

  // FIFO fill level as reported in TX_STATUS: saturates at 15.
  function automatic logic [3:0] sat_level(input logic [PW:0] lvl);
    logic [31:0] l;
    l = 32'(lvl);
    return (l > 32'd15) ? 4'hF : l[3:0];
  endfunction

  // Storage (never reset)
  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  tx_mem [TX_DEPTH];

  // Control state
  logic [PSW-1:0] presc;
  logic [63:0]    mtime, mtimecmp;
  logic [63:0]    mtime_nx, mtimecmp_nx;
  logic [PW:0]    wr_ptr, rd_ptr;

  // Request decode
  logic        req_live, sel_ok, size_h, size_w, sign_ext, misalign;
  logic        in_ram, in_mmio, tgt_ram, tgt_mmio, mmio_hit, addr_ok;
  logic        req_fault, req_ok, ram_wr, mmio_wr;
  logic        wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi;
  logic [7:0]  off;
  logic [AW-1:0] ram_idx;

  // Reset low squashes the request so nothing is written during reset.
  assign req_live = i_wb_stb & rst_n;
  assign sel_ok   = (i_wb_sel == 3'b000) | (i_wb_sel == 3'b001) | (i_wb_sel == 3'b010) |
                    (i_wb_sel == 3'b100) | (i_wb_sel == 3'b101);
  assign size_h   = (i_wb_sel[1:0] == 2'b01);
  assign size_w   = (i_wb_sel[1:0] == 2'b10);
  assign sign_ext = ~i_wb_sel[2];
  assign misalign = (size_h & i_wb_addr[0]) | (size_w & (|i_wb_addr[1:0]));

  assign in_ram   = (i_wb_addr[31:2] < 30'(RAM_WORDS));
  assign in_mmio  = (i_wb_addr[31:8] == MMIO_BASE[31:8]);
  assign tgt_ram  = in_ram;
  assign tgt_mmio = in_mmio & ~in_ram;
  assign off      = i_wb_addr[7:0];
  // Registers live at word offsets 0x00..0x14; only word accesses are legal.
  assign mmio_hit = size_w & (off[7:5] == 3'b000) & (off[1:0] == 2'b00) & (off[4:2] <= 3'd5);
  assign addr_ok  = tgt_ram | (tgt_mmio & mmio_hit);

  assign req_fault = req_live & (~sel_ok | misalign | ~addr_ok);
  assign req_ok    = req_live & ~req_fault;
  assign ram_wr    = req_ok & i_wb_we & tgt_ram;
  assign mmio_wr   = req_ok & i_wb_we & tgt_mmio;
  assign wr_mt_lo  = mmio_wr & (off[4:2] == 3'd0);
  assign wr_mt_hi  = mmio_wr & (off[4:2] == 3'd1);
  assign wr_cmp_lo = mmio_wr & (off[4:2] == 3'd2);
  assign wr_cmp_hi = mmio_wr & (off[4:2] == 3'd3);
  assign ram_idx   = i_wb_addr[AW+1:2];

  // TX FIFO status
  logic        tx_empty, tx_full, tx_pop, tx_push_req, tx_push, tx_drop;
  logic [PW:0] tx_level;

  assign tx_level    = wr_ptr - rd_ptr;
  assign tx_empty    = (wr_ptr == rd_ptr);
  assign tx_full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign tx_pop      = ~tx_empty & i_tx_ready;
  assign tx_push_req = mmio_wr & (off[4:2] == 3'd4);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
  assign o_tx_valid  = ~tx_empty;
  assign o_tx_data   = tx_mem[rd_ptr[PW-1:0]];

  // Load path: pick the source word, extract the lane, extend.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (tgt_ram) begin
      rd_word = ram[ram_idx];
    end else begin
      case (off[4:2])
        3'd0:    rd_word = mtime[31:0];
        3'd1:    rd_word = mtime[63:32];
        3'd2:    rd_word = mtimecmp[31:0];
        3'd3:    rd_word = mtimecmp[63:32];
        3'd5:    rd_word = {24'd0, sat_level(tx_level), 2'b00, tx_empty, tx_full};
        default: rd_word = '0;
      endcase
    end
    o_wb_dat = '0;
    if (req_ok && !i_wb_we) begin
      if (size_w)      o_wb_dat = rd_word;
      else if (size_h) o_wb_dat = ext_half(i_wb_addr[1] ? rd_word[31:16] : rd_word[15:0], sign_ext);
      else             o_wb_dat = ext_byte(rd_word[{i_wb_addr[1:0], 3'b000} +: 8], sign_ext);
    end
  end

  // Store path: replicate store data across lanes and build the byte mask.
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  always_comb begin
    wr_data = i_wb_dat;
    wr_mask = 4'b1111;
    if (size_h) begin
      wr_data = {2{i_wb_dat[15:0]}};
      wr_mask = i_wb_addr[1] ? 4'b1100 : 4'b0011;
    end else if (!size_w) begin
      wr_data = {4{i_wb_dat[7:0]}};
      wr_mask = 4'b0001 << i_wb_addr[1:0];
    end
  end

  // Data RAM byte-masked write.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) ram[ram_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
      end
    end
  end

  // Next timer values: a CPU write to a half wins over the tick.
  logic tick;
  assign tick = (presc == PS_LAST);
  always_comb begin
    mtime_nx    = mtime;
    mtimecmp_nx = mtimecmp;
    if (wr_mt_lo)      mtime_nx[31:0]  = i_wb_dat;
    else if (wr_mt_hi) mtime_nx[63:32] = i_wb_dat;
    else if (tick)     mtime_nx        = mtime + 64'd1;
    if (wr_cmp_lo)      mtimecmp_nx[31:0]  = i_wb_dat;
    else if (wr_cmp_hi) mtimecmp_nx[63:32] = i_wb_dat;
  end

  // Timer, interrupt and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      o_timer_irq <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      mtime       <= mtime_nx;
      mtimecmp    <= mtimecmp_nx;
      o_timer_irq <= (mtime_nx >= mtimecmp_nx);
      o_err       <= req_fault | tx_drop;
    end
  end

  // TX FIFO byte storage.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[wr_ptr[PW-1:0]] <= i_wb_dat[7:0];
  end

  // TX FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: RAM lanes, alignment faults, timer,
// TX FIFO fill/drain and reset behaviour.
module tb_data_bus_ctrl;

  localparam logic [31:0] MB     = 32'hFFFF_0000;
  localparam logic [31:0] MT_LO  = MB + 32'h00;
  localparam logic [31:0] CMP_LO = MB + 32'h08;
  localparam logic [31:0] CMP_HI = MB + 32'h0C;
  localparam logic [31:0] TX_D   = MB + 32'h10;
  localparam logic [31:0] TX_ST  = MB + 32'h14;
  localparam logic [2:0]  S_B = 3'b000, S_H = 3'b001, S_W = 3'b010, S_BU = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, we;
  logic [2:0]  sel;
  logic [31:0] addr, wdat;
  logic [31:0] rdat;
  logic        err, irq, tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int checks = 0;
  int failures = 0;

  data_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel), .i_wb_addr(addr), .i_wb_dat(wdat),
    .o_wb_dat(rdat), .o_err(err), .o_timer_irq(irq),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive one request for one cycle, return the
  // combinational read data and the o_err seen after the clock edge.
  task automatic do_req(input logic w, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e);
    stb = 1'b1; we = w; sel = s; addr = a; wdat = d;
    #1;
    rd = rdat;
    @(negedge clk);
    e = err;
    stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, m;
    logic        e, any_err, seen;

    rst_n = 1'b0; stb = 1'b0; we = 1'b0; sel = S_W; addr = '0; wdat = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_err", err, 0);
    check("rst_rdat_idle", rdat, 0);
    rst_n = 1'b1;

    // Timer: compare value 20, irq aligned with mtime reaching 20
    do_req(1, S_W, CMP_HI, 32'd0, rd, e);
    do_req(1, S_W, CMP_LO, 32'd20, rd, e);
    check("cmp_wr_err", e, 0);
    stb = 1'b1; we = 1'b0; sel = S_W; addr = MT_LO;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      #1;
      m = rdat;
      if (m == 32'd19) check("irq_at_19", irq, 0);
      if (m == 32'd20) begin
        check("irq_at_20", irq, 1);
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    stb = 1'b0;
    check("mtime_reached_20", seen, 1);
    @(negedge clk);
    check("irq_held", irq, 1);
    do_req(1, S_W, CMP_LO, 32'hFFFF_FFFF, rd, e);
    check("irq_fall", irq, 0);
    do_req(1, S_W, MT_LO, 32'd5, rd, e);
    do_req(0, S_W, MT_LO, 32'd0, rd, e);
    check("mtime_wr_5", rd, 32'd5);
    do_req(0, S_W, MT_LO, 32'd0, rd, e);
    check("mtime_then_6", rd, 32'd6);

    // Byte/half lanes
    do_req(1, S_W, 32'h10, 32'h1122_3344, rd, e);
    do_req(1, S_B, 32'h11, 32'h0000_00AA, rd, e);
    check("sb_err", e, 0);
    do_req(0, S_W, 32'h10, 32'd0, rd, e);
    check("lw_10", rd, 32'h1122_AA44);
    do_req(0, S_B, 32'h11, 32'd0, rd, e);
    check("lb_11", rd, 32'hFFFF_FFAA);
    do_req(0, S_BU, 32'h11, 32'd0, rd, e);
    check("lbu_11", rd, 32'h0000_00AA);
    do_req(0, S_H, 32'h12, 32'd0, rd, e);
    check("lh_12", rd, 32'h0000_1122);

    // Misalignment, back-to-back faults then a clean access
    do_req(1, S_W, 32'h0, 32'hCAFE_BABE, rd, e);
    do_req(0, S_W, 32'h2, 32'd0, rd, e);
    check("lw_mis_rd", rd, 0);
    check("lw_mis_err", e, 1);
    do_req(1, S_H, 32'h11, 32'h0000_BEEF, rd, e);
    check("sh_mis_err", e, 1);
    do_req(0, S_W, 32'h10, 32'd0, rd, e);
    check("sh_mis_nowrite", rd, 32'h1122_AA44);
    check("err_single_cycle", e, 0);
    do_req(0, S_W, 32'h0, 32'd0, rd, e);
    check("ram0_unchanged", rd, 32'hCAFE_BABE);

    // Other faults: unmapped, byte access to MMIO, illegal sel
    do_req(0, S_W, 32'h1000, 32'd0, rd, e);
    check("unmapped_rd", rd, 0);
    check("unmapped_err", e, 1);
    do_req(0, S_B, TX_ST, 32'd0, rd, e);
    check("mmio_byte_err", e, 1);
    do_req(0, 3'b011, 32'h10, 32'd0, rd, e);
    check("bad_sel_rd", rd, 0);
    check("bad_sel_err", e, 1);

    // TX fill with ready low
    tx_ready = 1'b0;
    any_err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      do_req(1, S_W, TX_D, 32'(i), rd, e);
      any_err |= e;
    end
    check("tx_fill_no_err", any_err, 0);
    do_req(1, S_W, TX_D, 32'd9, rd, e);
    check("tx_9th_err", e, 1);
    do_req(0, S_W, TX_ST, 32'd0, rd, e);
    check("tx_status_full", rd, 32'h81);
    do_req(0, S_W, TX_D, 32'd0, rd, e);
    check("tx_data_reads_0", rd, 0);
    check("tx_head_held", tx_data, 8'd1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, 8'(i));
      @(negedge clk);
    end
    check("drain_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    do_req(1, S_W, TX_D, 32'h10, rd, e);
    check("push_empty_valid_next", tx_valid, 1);
    for (int i = 1; i < 8; i++) do_req(1, S_W, TX_D, 32'h10 + 32'(i), rd, e);
    tx_ready = 1'b1;
    do_req(1, S_W, TX_D, 32'h55, rd, e);
    check("full_pushpop_err", e, 0);
    tx_ready = 1'b0;
    do_req(0, S_W, TX_ST, 32'd0, rd, e);
    check("full_pushpop_level", rd, 32'h81);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_drain_data", tx_data, (i < 7) ? 8'h11 + 8'(i) : 8'h55);
      @(negedge clk);
    end
    check("pp_drain_empty", tx_valid, 0);
    tx_ready = 1'b0;

    // Reset mid-activity
    do_req(1, S_W, CMP_LO, 32'd50, rd, e);
    for (int i = 0; i < 4; i++) do_req(1, S_W, TX_D, 32'h20 + 32'(i), rd, e);
    do_req(1, S_W, MT_LO, 32'd100, rd, e);
    check("pre_rst_irq", irq, 1);
    check("pre_rst_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", tx_valid, 0);
    check("rst_async_irq", irq, 0);
    stb = 1'b1; we = 1'b1; sel = S_W; addr = 32'h10; wdat = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    do_req(0, S_W, MT_LO, 32'd0, rd, e);
    check("post_rst_mtime", rd, 0);
    do_req(0, S_W, 32'h10, 32'd0, rd, e);
    check("ram_preserved", rd, 32'h1122_AA44);
    check("post_rst_irq", irq, 0);
    check("post_rst_valid", tx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
